// File: rtl/dcache_line_ram.sv
// dcache_line_ram: device-end line RAM behind the dcache line interface.
// Serves one full-line read or write at a time with a fixed response latency.
// Optional macro DCACHE_LINE_RAM_STATS_EN builds the accepted read/write counters;
// without it rd_count/wr_count are tied to zero.
module dcache_line_ram #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int DEPTH_LINES = 4096,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_addr_valid,
  output logic                  read_addr_ready,
  output logic [LINE_WIDTH-1:0] read_data,
  output logic                  read_data_valid,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  write_addr_valid,
  output logic                  write_addr_ready,
  input  logic [LINE_WIDTH-1:0] write_data,
  output logic                  write_resp_valid,
  input  logic [1:0]            size,
  input  logic [3:0]            strobe,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);

  localparam int IDX_W = $clog2(DEPTH_LINES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_RD_RESP = 3'd2;
  localparam logic [2:0] S_WR_WAIT = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  // Line store; contents survive RESET, start at zero.
  logic [LINE_WIDTH-1:0] mem [DEPTH_LINES] = '{default: '0};

  logic [2:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] read_data_q;

  logic [IDX_W-1:0] rd_idx_in, wr_idx_in, rd_load_idx;
  logic             idle, wr_accept, rd_accept, rd_load, mem_wr;

  // Byte offset and bits above the index are don't-care (aliasing wrap).
  logic unused_ok;
  assign unused_ok = ^{size, strobe, read_addr, write_addr};

  assign rd_idx_in = read_addr[IDX_W+3:4];
  assign wr_idx_in = write_addr[IDX_W+3:4];

  assign idle      = (state_q == S_IDLE);
  // Write wins when both requests are presented together.
  assign wr_accept = idle && write_addr_valid && !RESET;
  assign rd_accept = idle && read_addr_valid && !write_addr_valid && !RESET;

  assign read_addr_ready  = idle && !RESET && !write_addr_valid;
  assign write_addr_ready = idle && !RESET;
  assign read_data_valid  = (state_q == S_RD_RESP) && !RESET;
  assign write_resp_valid = (state_q == S_WR_RESP) && !RESET;
  assign read_data        = read_data_q;

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (wr_accept) begin
          idx_d   = wr_idx_in;
          wdata_d = write_data;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? S_WR_RESP : S_WR_WAIT;
        end else if (rd_accept) begin
          idx_d   = rd_idx_in;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? S_RD_RESP : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q <= 8'd1) state_d = S_RD_RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_WR_WAIT: begin
        if (cnt_q <= 8'd1) state_d = S_WR_RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (RESET) state_d = S_IDLE;
  end

  // Control registers; reset drops any pending operation.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Registered RAM read lands on the edge entering RD_RESP, then holds.
  // With LATENCY==1 the read is issued straight from the request address.
  assign rd_load     = !RESET && (((state_q == S_RD_WAIT) && (cnt_q <= 8'd1)) ||
                                  (rd_accept && (LATENCY == 1)));
  assign rd_load_idx = idle ? rd_idx_in : idx_q;

  always_ff @(posedge clk) begin
    if (RESET)        read_data_q <= '0;
    else if (rd_load) read_data_q <= mem[rd_load_idx];
  end

  // Commit the latched line at the end of WR_RESP, before readies come back.
  assign mem_wr = (state_q == S_WR_RESP) && !RESET;

  always_ff @(posedge clk) begin
    if (mem_wr) mem[idx_q] <= wdata_q;
  end

`ifdef DCACHE_LINE_RAM_STATS_EN
  logic [31:0] rd_count_q, wr_count_q;

  // Accepted-request counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (RESET) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (rd_accept) rd_count_q <= rd_count_q + 32'd1;
      if (wr_accept) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule
